// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block as 16 words and
// streams ROUNDS (W_t, K_t, t) tuples to the round datapath.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_word   message word input handshake
//   out_valid/out_ready         tuple output handshake
//   out_w, out_k, out_t         W_t, K_t and round index t
//   out_last                    tuple with t == ROUNDS-1
//   block_done                  pulse the cycle after the last tuple
module sha256_msg_schedule #(
    parameter int ROUNDS     = 64,
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [31:0] out_k,
    output logic [5:0]  out_t,
    output logic        out_last,
    output logic        block_done
);

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state;
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic [31:0] win [16];
    logic        done_q;

    logic        in_hs;
    logic        out_hs;
    logic [31:0] word_in;
    logic [31:0] w_next;

    assign in_hs  = in_valid && (state == LOAD);
    assign out_hs = out_ready && (state == EMIT);

    assign word_in = SWAP_BYTES
        ? {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]}
        : in_word;

    // Next schedule word from the 16-word window (window[0] = W_t).
    assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= LOAD;
            cnt    <= 4'd0;
            t      <= 6'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (in_hs) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= EMIT;
                            t     <= 6'd0;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (t == LAST_T) begin
                            state  <= LOAD;
                            cnt    <= 4'd0;
                            t      <= 6'd0;
                            done_q <= 1'b1;
                        end else begin
                            t <= t + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Window contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            win[cnt] <= word_in;
        end else if (out_hs && (t != LAST_T)) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= w_next;
        end
    end

    // All outputs decode from registered state only, so they stay
    // stable through output stalls.
    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == EMIT);
    assign out_w      = out_valid ? win[0] : 32'd0;
    assign out_k      = out_valid ? K_TAB[t] : 32'd0;
    assign out_t      = out_valid ? t : 6'd0;
    assign out_last   = out_valid && (t == LAST_T);
    assign block_done = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: random blocks, gaps and stalls
// checked against a full-array SHA-256 schedule model.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];

    localparam logic [31:0] KREF [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv  [2];
    logic        ir  [2];
    logic [31:0] iw  [2];
    logic        ov  [2];
    logic        orr [2];
    logic [31:0] ow  [2];
    logic [31:0] ok  [2];
    logic [5:0]  ot  [2];
    logic        ol  [2];
    logic        bd  [2];

    int total = 0;
    int bad   = 0;

    sha256_msg_schedule #(.ROUNDS(64), .SWAP_BYTES(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_word(iw[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_w(ow[0]), .out_k(ok[0]), .out_t(ot[0]),
        .out_last(ol[0]), .block_done(bd[0])
    );

    sha256_msg_schedule #(.ROUNDS(16), .SWAP_BYTES(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_word(iw[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_w(ow[1]), .out_k(ok[1]), .out_t(ot[1]),
        .out_last(ol[1]), .block_done(bd[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Textbook schedule: W[t] computed over the whole 64-entry array.
    task automatic expand(input blk_t m, output sch_t w);
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            a = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            b = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = b + w[i-7] + a + w[i-16];
        end
    endtask

    task automatic rand_blk(output blk_t m);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    task automatic abc_blk(output blk_t m);
        for (int i = 0; i < 16; i++) m[i] = 32'd0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
    endtask

    task automatic load(input int s, input blk_t m, input int gap_pct,
                        output int cyc);
        int  n;
        logic rdy;
        cyc = 0;
        for (int j = 0; j < 16; j++) begin
            while ($urandom_range(99) < gap_pct && cyc < 2000) begin
                iv[s] = 1'b0;
                iw[s] = $urandom;
                @(posedge clk); #1;
                cyc++;
            end
            iv[s] = 1'b1;
            iw[s] = m[j];
            n = 0;
            do begin
                rdy = ir[s];
                @(posedge clk); #1;
                cyc++;
                n++;
            end while (!rdy && n < 100);
            if (!rdy) check("load_timeout", 32'd0, 32'd1);
        end
        iv[s] = 1'b0;
    endtask

    task automatic recv(input int s, input sch_t w, input int rounds,
                        input int stall_pct, input int stop,
                        output sch_t got, output int cyc);
        int          t;
        logic        stalled;
        logic [31:0] pw;
        t = 0;
        cyc = 0;
        stalled = 1'b0;
        pw = 32'd0;
        while (t < stop && cyc < 5000) begin
            orr[s] = ($urandom_range(99) >= stall_pct);
            iv[s]  = 1'($urandom_range(1));
            iw[s]  = $urandom;
            if (ov[s]) begin
                check("in_ready_emit", 32'(ir[s]), 32'd0);
                check("done_emit", 32'(bd[s]), 32'd0);
                if (stalled) check("hold_w", ow[s], pw);
                if (orr[s]) begin
                    got[t] = ow[s];
                    check("w", ow[s], w[t]);
                    check("k", ok[s], KREF[t]);
                    check("t", 32'(ot[s]), 32'(t));
                    check("last", 32'(ol[s]), 32'(t == rounds - 1));
                    t++;
                end
                stalled = !orr[s];
                pw = ow[s];
            end
            @(posedge clk); #1;
            cyc++;
        end
        orr[s] = 1'b0;
        iv[s]  = 1'b0;
        if (t < stop) check("recv_timeout", 32'(t), 32'(stop));
    endtask

    task automatic after_block(input int s);
        check("done_pulse", 32'(bd[s]), 32'd1);
        check("ready_after", 32'(ir[s]), 32'd1);
        check("valid_after", 32'(ov[s]), 32'd0);
    endtask

    task automatic full_block(input int s, input blk_t m, input int rounds,
                              input int gap, input int stall);
        sch_t w, got;
        blk_t fed;
        int   c;
        for (int i = 0; i < 16; i++) fed[i] = (s == 1) ? bswap(m[i]) : m[i];
        expand(m, w);
        load(s, fed, gap, c);
        recv(s, w, rounds, stall, rounds, got, c);
        after_block(s);
        @(posedge clk); #1;
        check("done_once", 32'(bd[s]), 32'd0);
    endtask

    initial begin
        blk_t m, m2;
        sch_t w, got;
        int   c;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; iw[s] = 32'd0; orr[s] = 1'b0;
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(ir[0]), 32'd1);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_last", 32'(ol[0]), 32'd0);
        check("rst_done", 32'(bd[0]), 32'd0);
        check("rst_w", ow[0], 32'd0);
        check("rst_k", ok[0], 32'd0);
        check("rst_t", 32'(ot[0]), 32'd0);

        // "abc" block, no gaps, no stalls
        abc_blk(m);
        expand(m, w);
        load(0, m, 0, c);
        check("load_cycles", 32'(c), 32'd16);
        recv(0, w, 64, 0, 64, got, c);
        check("emit_cycles", 32'(c), 32'd64);
        check("abc_w16", got[16], 32'h61626380);
        check("abc_w17", got[17], 32'h000f0000);
        check("abc_w18", got[18], 32'h7da86405);
        check("abc_w19", got[19], 32'h600003c6);
        check("abc_w20", got[20], 32'h3e9d7b78);
        after_block(0);
        @(posedge clk); #1;
        check("done_once", 32'(bd[0]), 32'd0);

        // same block with input gaps and output stalls
        full_block(0, m, 64, 50, 50);

        for (int r = 0; r < 3; r++) begin
            rand_blk(m);
            full_block(0, m, 64, 30, 40);
        end

        // reset in the middle of EMIT
        rand_blk(m);
        expand(m, w);
        load(0, m, 0, c);
        recv(0, w, 64, 20, 30, got, c);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ready", 32'(ir[0]), 32'd1);
        check("midrst_valid", 32'(ov[0]), 32'd0);
        check("midrst_done", 32'(bd[0]), 32'd0);
        @(posedge clk); #1;
        check("midrst_done2", 32'(bd[0]), 32'd0);
        rand_blk(m);
        full_block(0, m, 64, 20, 20);

        // back-to-back blocks
        rand_blk(m);
        rand_blk(m2);
        expand(m, w);
        load(0, m, 0, c);
        recv(0, w, 64, 30, 64, got, c);
        after_block(0);
        expand(m2, w);
        load(0, m2, 0, c);
        check("b2b_load_cycles", 32'(c), 32'd16);
        recv(0, w, 64, 30, 64, got, c);
        after_block(0);
        @(posedge clk); #1;

        // byte-swapping instance, 16 rounds
        abc_blk(m);
        expand(m, w);
        for (int i = 0; i < 16; i++) m2[i] = bswap(m[i]);
        check("swap_in", m2[0], 32'h80636261);
        load(1, m2, 0, c);
        recv(1, w, 16, 0, 16, got, c);
        check("swap_w0", got[0], 32'h61626380);
        after_block(1);
        @(posedge clk); #1;
        rand_blk(m);
        full_block(1, m, 16, 30, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
